// File: rtl/tmr_pkg.sv
// Shared lane indices and helpers for the TMR voting blocks.
package tmr_pkg;

  typedef logic [1:0] lane_t;

  localparam lane_t LANE_A     = 2'd0;
  localparam lane_t LANE_B     = 2'd1;
  localparam lane_t LANE_C     = 2'd2;
  localparam lane_t LANE_MULTI = 2'd3;

  // Maps the per-lane mismatch flags {A,B,C} to the single faulty lane,
  // or LANE_MULTI when more than one lane disagrees with the vote.
  function automatic lane_t laneOf(input logic [2:0] mis);
    lane_t lane;
    case (mis)
      3'b100:  lane = LANE_A;
      3'b010:  lane = LANE_B;
      3'b001:  lane = LANE_C;
      default: lane = LANE_MULTI;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/majorityVoter.sv
// Single-bit 2-of-3 majority cell used to collapse the three lanes.
module majorityVoter (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_scrub_voter.sv
// Triplicated state register with bitwise majority vote, fault detection,
// a valid/ready fault report slot and a saturating error counter.
// Optional feature macro: TMR_SCRUB_EN (lanes reload from the vote each cycle).
module tmr_scrub_voter
  import tmr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_load,
  input  logic             inj_en,
  input  logic [1:0]       inj_lane,
  input  logic [WIDTH-1:0] inj_mask,
  output logic [WIDTH-1:0] out_data,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output lane_t            rpt_lane,
  output logic [WIDTH-1:0] rpt_mask,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_ovf,
  input  logic             err_clr
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] regA, regB, regC;
  logic [WIDTH-1:0] vote;
  logic [WIDTH-1:0] mA, mB, mC;
  logic [WIDTH-1:0] prevA, prevB, prevC;
  logic [WIDTH-1:0] baseA, baseB, baseC;
  logic [WIDTH-1:0] nextA, nextB, nextC;
  logic [2:0]       mis;
  logic             faultEvent;
  logic             capture;
  logic             dropEvent;

  for (genvar i = 0; i < WIDTH; i++) begin : gVote
    majorityVoter uVote (
      .a(regA[i]),
      .b(regB[i]),
      .c(regC[i]),
      .y(vote[i])
    );
  end

  assign out_data = vote;

  assign mA  = regA ^ vote;
  assign mB  = regB ^ vote;
  assign mC  = regC ^ vote;
  assign mis = {|mA, |mB, |mC};

`ifdef TMR_SCRUB_EN
  assign baseA = vote;
  assign baseB = vote;
  assign baseC = vote;
`else
  assign baseA = regA;
  assign baseB = regB;
  assign baseC = regC;
`endif

  assign nextA = (in_load ? in_data : baseA) ^ ((inj_en && inj_lane == LANE_A) ? inj_mask : '0);
  assign nextB = (in_load ? in_data : baseB) ^ ((inj_en && inj_lane == LANE_B) ? inj_mask : '0);
  assign nextC = (in_load ? in_data : baseC) ^ ((inj_en && inj_lane == LANE_C) ? inj_mask : '0);

  // A fault is new only when the mismatch pattern changed since last cycle,
  // so a persistent unscrubbed upset is reported once.
  assign faultEvent = (|mis) && ({mA, mB, mC} != {prevA, prevB, prevC});
  assign capture    = faultEvent && (!rpt_valid || rpt_ready);
  assign dropEvent  = faultEvent && !capture;

  // Lane registers plus the previous-cycle mismatch vectors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regA  <= RESET_VALUE;
      regB  <= RESET_VALUE;
      regC  <= RESET_VALUE;
      prevA <= '0;
      prevB <= '0;
      prevC <= '0;
    end else begin
      regA  <= nextA;
      regB  <= nextB;
      regC  <= nextC;
      prevA <= mA;
      prevB <= mB;
      prevC <= mC;
    end
  end

  // Report slot: holds one fault report until the consumer accepts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rpt_valid <= 1'b0;
      rpt_lane  <= LANE_A;
      rpt_mask  <= '0;
    end else if (capture) begin
      rpt_valid <= 1'b1;
      rpt_lane  <= laneOf(mis);
      rpt_mask  <= mA | mB | mC;
    end else if (rpt_valid && rpt_ready) begin
      rpt_valid <= 1'b0;
    end
  end

  // Saturating event counter and sticky overflow; a same-cycle event beats clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
      err_ovf <= 1'b0;
    end else if (err_clr) begin
      err_cnt <= faultEvent ? CNT_W'(1) : '0;
      err_ovf <= dropEvent;
    end else begin
      if (faultEvent && err_cnt != CntMax) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
      if (dropEvent) begin
        err_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tmr_scrub_voter.sv
// Self-checking bench for tmr_scrub_voter: directed scenarios plus a
// randomized run against a lane-level reference model.
// Honors TMR_SCRUB_EN so the model matches whichever build is compiled.
module tb_tmr_scrub_voter;

`ifdef TMR_SCRUB_EN
  localparam bit ScrubEn = 1'b1;
`else
  localparam bit ScrubEn = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic [7:0] inData;
  logic       inLoad;
  logic       injEn;
  logic [1:0] injLane;
  logic [7:0] injMask;
  logic [7:0] outData;
  logic       rptValid;
  logic       rptReady;
  logic [1:0] rptLane;
  logic [7:0] rptMask;
  logic [1:0] errCnt;
  logic       errOvf;
  logic       errClr;

  int tests = 0;
  int failures = 0;

  // Reference model state: three lanes, previous mismatches, report and counters.
  logic [7:0] mLane [3];
  logic [7:0] mPrev [3];
  bit         mValid;
  logic [1:0] mRptLane;
  logic [7:0] mRptMask;
  int         mCnt;
  bit         mOvf;

  tmr_scrub_voter #(
    .WIDTH(8),
    .CNT_W(2),
    .RESET_VALUE(8'h5A)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .in_data(inData),
    .in_load(inLoad),
    .inj_en(injEn),
    .inj_lane(injLane),
    .inj_mask(injMask),
    .out_data(outData),
    .rpt_valid(rptValid),
    .rpt_ready(rptReady),
    .rpt_lane(rptLane),
    .rpt_mask(rptMask),
    .err_cnt(errCnt),
    .err_ovf(errOvf),
    .err_clr(errClr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] modelVote();
    logic [7:0] v;
    for (int b = 0; b < 8; b++) begin
      int ones;
      ones = int'(mLane[0][b]) + int'(mLane[1][b]) + int'(mLane[2][b]);
      v[b] = (ones >= 2);
    end
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mLane[i] = 8'h5A;
      mPrev[i] = 8'h00;
    end
    mValid = 0; mRptLane = 2'd0; mRptMask = 8'h00; mCnt = 0; mOvf = 0;
  endtask

  // Drives one cycle of inputs, advances the model, then waits past the edge.
  task automatic applyStimulus(input bit load, input logic [7:0] data, input bit inj,
                               input logic [1:0] lane, input logic [7:0] mask,
                               input bit ready, input bit clr);
    logic [7:0] v;
    logic [7:0] m [3];
    logic [7:0] nl [3];
    bit changed, evt, cap;
    int nBad, badIdx;
    inLoad = load; inData = data; injEn = inj; injLane = lane; injMask = mask;
    rptReady = ready; errClr = clr;
    v = modelVote();
    changed = 0; nBad = 0; badIdx = 0;
    for (int i = 0; i < 3; i++) begin
      m[i] = mLane[i] ^ v;
      if (m[i] != mPrev[i]) changed = 1;
      if (m[i] != 0) begin nBad++; badIdx = i; end
    end
    evt = (nBad > 0) && changed;
    cap = evt && (!mValid || ready);
    for (int i = 0; i < 3; i++) begin
      nl[i] = load ? data : (ScrubEn ? v : mLane[i]);
      if (inj && int'(lane) == i) nl[i] = nl[i] ^ mask;
    end
    if (cap) begin
      mValid = 1;
      mRptLane = (nBad == 1) ? 2'(badIdx) : 2'd3;
      mRptMask = m[0] | m[1] | m[2];
    end else if (mValid && ready) begin
      mValid = 0;
    end
    if (clr) begin
      mCnt = evt ? 1 : 0;
      mOvf = evt && !cap;
    end else begin
      if (evt && mCnt < 3) mCnt++;
      if (evt && !cap) mOvf = 1;
    end
    for (int i = 0; i < 3; i++) begin
      mPrev[i] = m[i];
      mLane[i] = nl[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ready);
    applyStimulus(0, 8'h00, 0, 2'd3, 8'h00, ready, 0);
  endtask

  task automatic quiesce(input logic [7:0] val);
    applyStimulus(1, val, 0, 2'd3, 8'h00, 1, 1);
    applyStimulus(1, val, 0, 2'd3, 8'h00, 1, 1);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    inLoad = 0; inData = 0; injEn = 0; injLane = 2'd3; injMask = 0; rptReady = 0; errClr = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (outData !== 8'h5A) begin failures++; $display("[TB] FAIL reset_out: got %h expected 5a", outData); end
    tests++; if (rptValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", rptValid); end
    tests++; if (errCnt !== 2'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d expected 0", errCnt); end
    tests++; if (errOvf !== 1'b0 || rptMask !== 8'h00 || rptLane !== 2'd0) begin
      failures++; $display("[TB] FAIL reset_misc: got ovf=%b mask=%h lane=%0d expected 0/00/0", errOvf, rptMask, rptLane);
    end
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    applyStimulus(1, 8'hC3, 0, 2'd3, 8'h00, 1, 0);
    tests++; if (outData !== 8'hC3) begin failures++; $display("[TB] FAIL load_out: got %h expected c3", outData); end
    idle(1);
    tests++; if (rptValid !== 1'b0 || errCnt !== 2'd0) begin
      failures++; $display("[TB] FAIL load_noevent: got valid=%b cnt=%0d expected 0/0", rptValid, errCnt);
    end
  endtask

  task automatic test_single_fault();
    applyStimulus(0, 8'h00, 1, 2'd1, 8'h01, 0, 0);
    tests++; if (outData !== 8'hC3) begin failures++; $display("[TB] FAIL single_out: got %h expected c3", outData); end
    tests++; if (rptValid !== 1'b0) begin failures++; $display("[TB] FAIL single_early: got valid=%b expected 0", rptValid); end
    idle(0);
    tests++; if (rptValid !== 1'b1 || rptLane !== 2'd1 || rptMask !== 8'h01 || errCnt !== 2'd1) begin
      failures++; $display("[TB] FAIL single_report: got v=%b lane=%0d mask=%h cnt=%0d expected 1/1/01/1", rptValid, rptLane, rptMask, errCnt);
    end
    tests++; if (outData !== 8'hC3) begin failures++; $display("[TB] FAIL single_out2: got %h expected c3", outData); end
    repeat (3) idle(1);
    tests++; if (errCnt !== 2'd1 || rptValid !== 1'b0) begin
      failures++; $display("[TB] FAIL single_once: got cnt=%0d valid=%b expected 1/0", errCnt, rptValid);
    end
  endtask

  task automatic test_persistent();
    quiesce(8'hC3);
    applyStimulus(0, 8'h00, 1, 2'd0, 8'h80, 0, 0);
    repeat (5) idle(0);
    tests++; if (errCnt !== 2'd1 || errOvf !== 1'b0) begin
      failures++; $display("[TB] FAIL persist_cnt: got cnt=%0d ovf=%b expected 1/0", errCnt, errOvf);
    end
    tests++; if (rptValid !== 1'b1 || rptLane !== 2'd0 || rptMask !== 8'h80) begin
      failures++; $display("[TB] FAIL persist_rpt: got v=%b lane=%0d mask=%h expected 1/0/80", rptValid, rptLane, rptMask);
    end
    applyStimulus(1, 8'hC3, 0, 2'd3, 8'h00, 0, 0);
    repeat (2) idle(0);
    tests++; if (errCnt !== 2'd1 || errOvf !== 1'b0 || outData !== 8'hC3) begin
      failures++; $display("[TB] FAIL persist_load: got cnt=%0d ovf=%b out=%h expected 1/0/c3", errCnt, errOvf, outData);
    end
  endtask

  task automatic test_overflow();
    quiesce(8'hC3);
    applyStimulus(0, 8'h00, 1, 2'd0, 8'h01, 0, 0);
    applyStimulus(0, 8'h00, 1, 2'd2, 8'h10, 0, 0);
    repeat (2) idle(0);
    tests++; if (errOvf !== 1'b1 || errCnt !== 2'd2) begin
      failures++; $display("[TB] FAIL ovf_flag: got ovf=%b cnt=%0d expected 1/2", errOvf, errCnt);
    end
    tests++; if (rptValid !== 1'b1 || rptLane !== 2'd0 || rptMask !== 8'h01) begin
      failures++; $display("[TB] FAIL ovf_keep: got v=%b lane=%0d mask=%h expected 1/0/01", rptValid, rptLane, rptMask);
    end
  endtask

  task automatic test_load_inject();
    quiesce(8'hC3);
    applyStimulus(1, 8'h00, 1, 2'd2, 8'h0F, 0, 0);
    tests++; if (outData !== 8'h00) begin failures++; $display("[TB] FAIL ldinj_out: got %h expected 00", outData); end
    idle(0);
    tests++; if (rptValid !== 1'b1 || rptLane !== 2'd2 || rptMask !== 8'h0F || errCnt !== 2'd1) begin
      failures++; $display("[TB] FAIL ldinj_rpt: got v=%b lane=%0d mask=%h cnt=%0d expected 1/2/0f/1", rptValid, rptLane, rptMask, errCnt);
    end
  endtask

  task automatic test_saturation();
    quiesce(8'h00);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 8'h00, 1, 2'(k % 3), 8'(1 << k), 1, 0);
      idle(1);
      idle(1);
      applyStimulus(1, 8'h00, 0, 2'd3, 8'h00, 1, 0);
    end
    tests++; if (errCnt !== 2'd3 || errOvf !== 1'b0) begin
      failures++; $display("[TB] FAIL sat_cnt: got cnt=%0d ovf=%b expected 3/0", errCnt, errOvf);
    end
    applyStimulus(0, 8'h00, 1, 2'd0, 8'h40, 1, 0);
    applyStimulus(0, 8'h00, 0, 2'd3, 8'h00, 1, 1);
    tests++; if (errCnt !== 2'd1) begin failures++; $display("[TB] FAIL sat_clr_event: got cnt=%0d expected 1", errCnt); end
  endtask

  task automatic test_reset_mid_report();
    quiesce(8'h00);
    applyStimulus(0, 8'h00, 1, 2'd1, 8'h02, 0, 0);
    idle(0);
    rstn = 1'b0;
    #2;
    tests++; if (rptValid !== 1'b0 || errCnt !== 2'd0 || outData !== 8'h5A || rptMask !== 8'h00) begin
      failures++; $display("[TB] FAIL midrst: got v=%b cnt=%0d out=%h mask=%h expected 0/0/5a/00", rptValid, errCnt, outData, rptMask);
    end
    modelReset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(1);
    tests++; if (outData !== 8'h5A || rptValid !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_after: got out=%h v=%b expected 5a/0", outData, rptValid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bit load, inj, ready, clr;
      load  = ($urandom_range(0, 9) == 0);
      inj   = ($urandom_range(0, 2) == 0);
      ready = $urandom_range(0, 1) == 1;
      clr   = ($urandom_range(0, 19) == 0);
      applyStimulus(load, 8'($urandom), inj, 2'($urandom_range(0, 3)), 8'($urandom), ready, clr);
      tests++; if (outData !== modelVote()) begin
        failures++; $display("[TB] FAIL rnd_out[%0d]: got %h expected %h", n, outData, modelVote());
      end
      tests++; if (rptValid !== mValid || (mValid && (rptLane !== mRptLane || rptMask !== mRptMask))) begin
        failures++; $display("[TB] FAIL rnd_rpt[%0d]: got v=%b lane=%0d mask=%h expected %b/%0d/%h", n, rptValid, rptLane, rptMask, mValid, mRptLane, mRptMask);
      end
      tests++; if (errCnt !== 2'(mCnt) || errOvf !== mOvf) begin
        failures++; $display("[TB] FAIL rnd_cnt[%0d]: got cnt=%0d ovf=%b expected %0d/%b", n, errCnt, errOvf, mCnt, mOvf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_single_fault();
    test_persistent();
    test_overflow();
    test_load_inject();
    test_saturation();
    test_reset_mid_report();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
